// File: rtl/clk_div_pkg.sv
// Shared definitions for the even-ratio clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

    // A zero half-period has no meaning and is rejected on the config port.
    localparam int unsigned ILLEGAL_HALF = 0;
    localparam int unsigned DEF_HALF     = 2;

endpackage

// File: rtl/even_clk_div_ctrl_if.sv
// Configuration handshake bundle for even_clk_div_ctrl (valid/ready plus error pulse).
interface even_clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_half, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_phase_counter.sv
// Half-period counter and 50%-duty toggle generator; holds the active ratio and
// swaps in a new one only at the 0->1 boundary so the output never glitches.
module clk_div_phase_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             hold_low,
    input  logic             set_en,
    input  logic [CNT_W-1:0] set_half,
    input  logic             ld_en,
    input  logic [CNT_W-1:0] ld_half,
    output logic             boundary,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic             tc;

    assign tc       = run && (cnt == active_half - CNT_W'(1));
    assign boundary = tc && !clk_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            active_half <= CNT_W'(DEFAULT_HALF);
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            if (start) begin
                cnt       <= '0;
                clk_out   <= 1'b1;
                rise_tick <= 1'b1;
            end else if (tc) begin
                cnt <= '0;
                if (clk_out) begin
                    clk_out   <= 1'b0;
                    fall_tick <= 1'b1;
                end else if (!hold_low) begin
                    clk_out   <= 1'b1;
                    rise_tick <= 1'b1;
                end
            end else if (run) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Direct loads only happen while stopped; deferred loads wait for the boundary.
            if (set_en) begin
                active_half <= set_half;
            end else if (boundary && ld_en) begin
                active_half <= ld_half;
            end
        end
    end

endmodule

// File: rtl/even_clk_div_ctrl.sv
// Even-ratio clock divider controller: FSM and config handshake around the phase counter.
// Optional period counter output enabled by defining EVEN_CLK_DIV_PERIOD_CNT_EN.
module even_clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    even_clk_div_ctrl_if.slave  cfg,
    output logic                clk_out,
    output logic                rise_tick,
    output logic                fall_tick,
    output logic                busy
`ifdef EVEN_CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]         period_cnt
`endif
);

    state_e           state;
    logic [CNT_W-1:0] pend_half;
    logic             pend_vld;
    logic             ready;
    logic             xfer;
    logic             legal;
    logic             boundary;
    logic             start;

    assign ready         = (state == IDLE) || (state == RUN);
    assign cfg.cfg_ready = ready;
    assign busy          = (state != IDLE);
    assign xfer          = cfg.cfg_valid && ready;
    assign legal         = (cfg.cfg_half != CNT_W'(ILLEGAL_HALF));
    assign start         = (state == IDLE) && enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pend_vld    <= 1'b0;
            pend_half   <= '0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= xfer && !legal;
            case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (xfer && legal) begin
                        pend_half <= cfg.cfg_half;
                        pend_vld  <= 1'b1;
                    end
                    // A stop request wins over entering PEND; the captured ratio rides along.
                    if (!enable) begin
                        state <= STOP;
                    end else if (xfer && legal) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        pend_vld <= 1'b0;
                        state    <= enable ? RUN : STOP;
                    end else if (!enable) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (boundary) begin
                        pend_vld <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    clk_div_phase_counter #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .run       (state != IDLE),
        .hold_low  (state == STOP),
        .set_en    ((state == IDLE) && xfer && legal),
        .set_half  (cfg.cfg_half),
        .ld_en     (pend_vld),
        .ld_half   (pend_half),
        .boundary  (boundary),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

`ifdef EVEN_CLK_DIV_PERIOD_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= 16'd0;
        end else if (start) begin
            period_cnt <= 16'd0;
        end else if (rise_tick) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_even_clk_div_ctrl.sv
// Bench for even_clk_div_ctrl: directed table, corner-case sequences and random stimulus
// checked against a phase-countdown reference model.
module tb_even_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clk_out, rise_tick, fall_tick, busy;
`ifdef EVEN_CLK_DIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    even_clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    even_clk_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfg_if),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .busy      (busy)
`ifdef EVEN_CLK_DIV_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: remaining cycles in the current phase plus a queue of deferred ratios.
    bit m_run, m_lvl, m_stop, m_rise, m_fall, m_err;
    int m_left, m_half = 2;
    int m_pend[$];

    function automatic bit m_ready();
        return !m_run || (!m_stop && m_pend.size() == 0);
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit v, input int h);
        bit rdy, acc, was_stop;
        rdy    = m_ready();
        m_rise = 0;
        m_fall = 0;
        m_err  = 0;
        if (r) begin
            m_run = 0; m_lvl = 0; m_stop = 0; m_left = 0; m_half = 2;
            m_pend.delete();
            return;
        end
        acc = v && rdy && (h != 0);
        if (v && rdy && h == 0) m_err = 1;
        if (!m_run) begin
            if (acc) m_half = h;
            if (e) begin
                m_run = 1; m_lvl = 1; m_left = m_half; m_rise = 1; m_stop = 0;
            end
        end else begin
            was_stop = m_stop;
            m_left--;
            if (m_left == 0) begin
                if (m_lvl) begin
                    m_lvl = 0; m_fall = 1; m_left = m_half;
                end else begin
                    if (m_pend.size() > 0) m_half = m_pend.pop_front();
                    if (was_stop) begin
                        m_run = 0; m_stop = 0;
                    end else begin
                        m_lvl = 1; m_rise = 1; m_left = m_half;
                    end
                end
            end
            if (acc) m_pend.push_back(h);
            if (!e && m_run) m_stop = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {clk_out, rise_tick, fall_tick, cfg_if.cfg_err, busy, cfg_if.cfg_ready};
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input int h);
        reset            = r;
        enable           = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_half  = h[CNT_W-1:0];
        @(posedge clk);
        model_edge(r, e, v, h);
        #1;
        check("model", {26'd0, outs()},
              {26'd0, m_lvl, m_rise, m_fall, m_err, m_run, m_ready()});
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            step(0, 1, 0, 0);
            n++;
            if (rise_tick === 1'b1) break;
        end
    endtask

    task automatic measure(input bit lvl, output int len);
        len = 1;
        for (int k = 0; k < 64; k++) begin
            step(0, 1, 0, 0);
            if (clk_out !== lvl) break;
            len++;
        end
    endtask

    typedef struct {
        bit         r;
        bit         e;
        bit         v;
        int         h;
        logic [5:0] exp;   // {clk_out, rise, fall, cfg_err, busy, cfg_ready}
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n, len;
        bit prev_rise, en_r;

        tbl[0]  = '{1, 0, 0, 0, 6'b000001};
        tbl[1]  = '{0, 1, 0, 0, 6'b110011};
        tbl[2]  = '{0, 1, 0, 0, 6'b100011};
        tbl[3]  = '{0, 1, 0, 0, 6'b001011};
        tbl[4]  = '{0, 1, 0, 0, 6'b000011};
        tbl[5]  = '{0, 1, 0, 0, 6'b110011};
        tbl[6]  = '{0, 1, 0, 0, 6'b100011};
        tbl[7]  = '{0, 1, 0, 0, 6'b001011};
        tbl[8]  = '{0, 1, 0, 0, 6'b000011};
        tbl[9]  = '{0, 1, 1, 0, 6'b110111};
        tbl[10] = '{0, 1, 0, 0, 6'b100011};
        tbl[11] = '{0, 1, 0, 0, 6'b001011};
        tbl[12] = '{0, 1, 0, 0, 6'b000011};
        tbl[13] = '{0, 1, 0, 0, 6'b110011};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_half  = '0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].h);
            check($sformatf("tbl%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
        end

        // Ratio change offered during the first high cycle at HALF=2.
        step(0, 1, 1, 3);
        check("pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        wait_rise(n);
        check("pend_wait", n, 3);
        check("ready_after_boundary", {31'd0, cfg_if.cfg_ready}, 32'd1);
        measure(1'b1, len);
        check("new_high", len, 3);
        measure(1'b0, len);
        check("new_low", len, 3);
        measure(1'b1, len);
        check("steady_high", len, 3);
        measure(1'b0, len);
        check("steady_low", len, 3);

        // Stop requested one cycle into a HALF=3 high phase.
        step(0, 0, 0, 0);
        check("stop_first", {30'd0, clk_out, busy}, 32'd3);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("stop_seq%0d", k), {30'd0, clk_out, busy},
                  {30'd0, (k == 0) ? 1'b1 : 1'b0, (k < 4) ? 1'b1 : 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0);
            if (k == 0) check("restart_rise", {31'd0, rise_tick}, 32'd1);
        end
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0);
        check("stopped_idle", {29'd0, clk_out, rise_tick, busy}, 32'd0);

        // Divide-by-2.
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        prev_rise = rise_tick;
        check("div2_start", {31'd0, rise_tick}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0);
            check("div2_alt", {30'd0, rise_tick, fall_tick}, {30'd0, !prev_rise, prev_rise});
            prev_rise = rise_tick;
        end

        // Reset while a HALF=4 change is pending.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 4);
        check("rst_pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step(1, 1, 0, 0);
        check("rst_clk", {30'd0, clk_out, cfg_if.cfg_ready}, 32'd1);
        step(0, 1, 0, 0);
        measure(1'b1, len);
        check("rst_high", len, 2);
        measure(1'b0, len);
        check("rst_low", len, 2);

        // Random traffic.
        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en_r = !en_r;
            step($urandom_range(0, 99) == 0, en_r, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
